// File: rtl/keypad_encoder.sv
// keypad_encoder: scans and debounces a 4x4 keypad and emits one key event per press
// Ports: CLK/RST clock and sync active-high reset; row active-low one-hot row drive;
// col async active-low column sense; startSet event strobe; num digit 0-9;
// start/clear/enter function-key flags (num and flags held until the next accepted key).
module keypad_encoder #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CYC = 8,
  parameter int STROBE_CYC   = 5
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic       startSet,
  output logic [4:0] num,
  output logic       start,
  output logic       clear,
  output logic       enter
);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, STROBE, WAIT_RELEASE} state_t;
  localparam int DW = $clog2(SCAN_DIV) + 1;
  localparam int CW = $clog2(DEBOUNCE_CYC + STROBE_CYC + 1) + 1;
  state_t state_q, state_d;
  logic [3:0] sync_q, cs_q, pat_q, pat_d;
  logic [1:0] ridx_q, ridx_d, idle_q, idle_d, kc;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic set_q, set_d, start_q, start_d, clear_q, clear_d, enter_q, enter_d, arm_q, arm_d;
  logic [4:0] num_q, num_d, digit;
  logic [3:0] low, pl;
  logic one_low, sample, fn, unused;
  assign low     = ~cs_q;
  assign one_low = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  assign sample  = div_q == DW'(SCAN_DIV - 1);
  assign pl      = ~pat_q;
  assign kc      = pl[0] ? 2'd0 : pl[1] ? 2'd1 : pl[2] ? 2'd2 : 2'd3;
  assign fn      = kc == 2'd3 && ridx_q != 2'd3;
  assign unused  = ridx_q == 2'd3 && kc != 2'd1;
  assign digit   = (ridx_q == 2'd3) ? 5'd0 : 5'(ridx_q) * 5'd3 + 5'(kc) + 5'd1;
  assign row      = ~(4'b0001 << ridx_q);
  assign startSet = set_q;
  assign num      = num_q;
  assign start    = start_q;
  assign clear    = clear_q;
  assign enter    = enter_q;
  // A key still held through reset must not fire: scanning only arms after
  // one full round of rows samples with no key down.
  always_comb begin
    state_d = state_q;
    ridx_d  = ridx_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    set_d   = set_q;
    num_d   = num_q;
    start_d = start_q;
    clear_d = clear_q;
    enter_d = enter_q;
    idle_d  = idle_q;
    arm_d   = arm_q;
    case (state_q)
      SCAN: begin
        div_d = sample ? '0 : div_q + DW'(1);
        if (sample) begin
          idle_d = (cs_q == 4'hF) ? idle_q + 2'd1 : 2'd0;
          arm_d  = arm_q | (cs_q == 4'hF && idle_q == 2'd3);
          if (one_low && arm_q) begin
            pat_d   = cs_q;
            cnt_d   = CW'(1);
            state_d = DEBOUNCE;
          end else
            ridx_d = ridx_q + 2'd1;
        end
      end
      DEBOUNCE: begin
        if (cs_q == pat_q) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
            state_d = unused ? WAIT_RELEASE : STROBE;
            cnt_d   = unused ? '0 : CW'(1);
            set_d   = !unused;
            num_d   = (unused || fn) ? num_q : digit;
            start_d = unused ? start_q : fn && ridx_q == 2'd0;
            clear_d = unused ? clear_q : fn && ridx_q == 2'd1;
            enter_d = unused ? enter_q : fn && ridx_q == 2'd2;
          end
        end else begin
          cnt_d   = '0;
          state_d = SCAN;
          ridx_d  = ridx_q + 2'd1;
          div_d   = '0;
        end
      end
      STROBE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STROBE_CYC)) begin
          set_d   = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        cnt_d = (cs_q == 4'hF) ? cnt_q + CW'(1) : '0;
        if (cs_q == 4'hF && cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = SCAN;
          ridx_d  = 2'd0;
          div_d   = '0;
        end
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= SCAN;
      sync_q  <= 4'hF;
      cs_q    <= 4'hF;
      pat_q   <= 4'hF;
      ridx_q  <= 2'd0;
      div_q   <= '0;
      cnt_q   <= '0;
      set_q   <= 1'b0;
      num_q   <= 5'd0;
      start_q <= 1'b0;
      clear_q <= 1'b0;
      enter_q <= 1'b0;
      idle_q  <= 2'd0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= col;
      cs_q    <= sync_q;
      pat_q   <= pat_d;
      ridx_q  <= ridx_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      num_q   <= num_d;
      start_q <= start_d;
      clear_q <= clear_d;
      enter_q <= enter_d;
      idle_q  <= idle_d;
      arm_q   <= arm_d;
    end
  end
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: event-queue model check of keypad_encoder with directed and random presses
module tb_keypad_encoder;
  localparam int STROBE_CYC = 5;
  logic CLK = 1'b0, RST = 1'b1;
  logic [3:0] row, col;
  logic startSet, start, clear, enter;
  logic [4:0] num;
  logic [15:0] keys = '0;
  int tests = 0, fails = 0, pulses = 0, width = 0, k = 0;
  int kv[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, -1, 0, -1, -1};
  logic [3:0] rs[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int exq[$];
  logic [4:0] mnum = '0;
  logic ms = 0, mc = 0, me = 0, prev_set = 0, prev_rst = 1;
  always #5 CLK = ~CLK;
  keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE_CYC(8), .STROBE_CYC(STROBE_CYC)) dut (
    .CLK(CLK), .RST(RST), .row(row), .col(col), .startSet(startSet),
    .num(num), .start(start), .clear(clear), .enter(enter));
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge CLK) begin
    if (prev_rst) begin
      mnum = '0; ms = 0; mc = 0; me = 0; width = 0;
      exq.delete();
      chk("reset_startSet", int'(startSet), 0);
      chk("reset_row", int'(row), 4'b1110);
    end else begin
      if (startSet && !prev_set) begin
        pulses++;
        if (exq.size() == 0) chk("unexpected_pulse", 1, 0);
        else begin
          k = exq.pop_front();
          if (k < 10) begin
            mnum = 5'(k); ms = 0; mc = 0; me = 0;
          end else begin
            ms = (k == 10); mc = (k == 11); me = (k == 12);
          end
        end
      end
      if (startSet) width++;
      else if (prev_set) begin
        chk("pulse_width", width, STROBE_CYC);
        width = 0;
      end
    end
    chk("num", int'(num), int'(mnum));
    chk("flags", int'({start, clear, enter}), int'({ms, mc, me}));
    chk("row_onehot", $countones(~row), 1);
    prev_set = startSet;
    prev_rst = RST;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic press(input int key, input int hold, input int gap);
    if (kv[key] >= 0) exq.push_back(kv[key]);
    keys[key] = 1'b1;
    tick(hold);
    keys[key] = 1'b0;
    tick(gap);
    chk("missing_pulse", exq.size(), 0);
  endtask
  initial begin
    int p0, n;
    tick(3);
    RST = 1'b0;
    @(negedge CLK);
    for (int i = 1; i <= 32; i++) begin
      @(negedge CLK);
      chk("idle_row_seq", int'(row), int'(rs[(i / 4) % 4]));
    end
    chk("idle_num", int'(num), 0);
    @(posedge CLK);
    #1;
    p0 = pulses;
    press(2, 40, 40);
    chk("key3_pulses", pulses - p0, 1);
    chk("key3_num", int'(num), 3);
    chk("key3_flags", int'({start, clear, enter}), 0);
    p0 = pulses;
    press(3, 60, 40);
    chk("start_flag", int'(start), 1);
    press(0, 60, 40);
    chk("key1_num", int'(num), 1);
    press(5, 60, 40);
    press(11, 60, 40);
    chk("seq_pulses", pulses - p0, 4);
    chk("enter_num", int'(num), 5);
    chk("enter_flag", int'(enter), 1);
    p0 = pulses;
    exq.push_back(4);
    for (int i = 0; i < 7; i++) begin
      keys[4] = ~keys[4];
      tick(3);
    end
    chk("bounce_no_pulse", pulses - p0, 0);
    tick(45);
    keys[4] = 1'b0;
    tick(40);
    chk("bounce_missing", exq.size(), 0);
    chk("bounce_pulses", pulses - p0, 1);
    chk("key4_num", int'(num), 4);
    p0 = pulses;
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    tick(50);
    keys[1:0] = 2'b00;
    tick(40);
    press(12, 50, 40);
    chk("multi_unused_pulses", pulses - p0, 0);
    press(13, 50, 40);
    chk("key0_num", int'(num), 0);
    exq.push_back(11);
    keys[7] = 1'b1;
    n = 0;
    while (!startSet && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk("clear_pulse_seen", int'(startSet), 1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_startSet", int'(startSet), 0);
    chk("rst_clear", int'(clear), 0);
    chk("rst_num", int'(num), 0);
    chk("rst_row", int'(row), 4'b1110);
    p0 = pulses;
    tick(60);
    chk("held_after_rst", pulses - p0, 0);
    keys[7] = 1'b0;
    tick(40);
    press(7, 60, 40);
    chk("clear_again_flag", int'(clear), 1);
    chk("clear_again_num", int'(num), 0);
    repeat (10) press($urandom_range(0, 15), $urandom_range(45, 70), $urandom_range(40, 60));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
